// File: rtl/config_chain_loader.sv
// Serializes bitstream words onto a config DFF chain and returns the displaced bits as readback words.
// Latency: bit 0 of a word is on ccff_head the cycle after acceptance; a stalled readback word holds off shifting.
module config_chain_loader #(
  parameter int CHAIN_LEN = 400,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  iss_cnt, smp_cnt, word_cnt;
  logic [IDX_W-1:0]  iss_idx, smp_idx;
  logic [WORD_W-1:0] buf_dat, acc, src_dat;
  logic              buf_full;
  logic              xfer, iss_last, smp_last, smp_done, stall, shift_go;

  // Bits are issued one cycle ahead of the chain edge so that chain_clk_en and
  // ccff_head come straight from flops; the tail is sampled while the enable is high.
  always_comb begin
    iss_last   = (iss_idx == IDX_W'(WORD_W - 1)) || (iss_cnt == CNT_W'(CHAIN_LEN - 1));
    smp_last   = (smp_idx == IDX_W'(WORD_W - 1)) || (smp_cnt == CNT_W'(CHAIN_LEN - 1));
    smp_done   = chain_clk_en && smp_last;
    stall      = iss_last && ((rb_valid && !rb_ready) || smp_done);
    word_ready = (state == SHIFT) && (word_cnt < CNT_W'(NWORDS)) &&
                 (!buf_full || (!stall && iss_last));
    xfer       = word_valid && word_ready;
    src_dat    = buf_full ? buf_dat : word_data;
    shift_go   = (state == SHIFT) && (buf_full || xfer) && !stall;
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (chain_clk_en && smp_cnt == CNT_W'(CHAIN_LEN - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (rb_valid && rb_ready) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      iss_cnt      <= '0;
      smp_cnt      <= '0;
      word_cnt     <= '0;
      iss_idx      <= '0;
      smp_idx      <= '0;
      buf_dat      <= '0;
      buf_full     <= 1'b0;
      acc          <= '0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
      rb_data      <= '0;
      rb_valid     <= 1'b0;
    end else begin
      chain_clk_en <= shift_go;
      if (state == IDLE && start) begin
        iss_cnt  <= '0;
        smp_cnt  <= '0;
        word_cnt <= '0;
        iss_idx  <= '0;
        smp_idx  <= '0;
        buf_dat  <= '0;
        buf_full <= 1'b0;
        acc      <= '0;
      end else begin
        if (xfer) word_cnt <= word_cnt + CNT_W'(1);
        if (shift_go) begin
          ccff_head <= src_dat[0];
          iss_cnt   <= iss_cnt + CNT_W'(1);
          iss_idx   <= iss_last ? '0 : iss_idx + IDX_W'(1);
          // Last used bit leaves: the buffer refills only if a word arrives now.
          if (iss_last) begin
            buf_full <= buf_full && xfer;
            buf_dat  <= word_data;
          end else begin
            buf_full <= 1'b1;
            buf_dat  <= src_dat >> 1;
          end
        end else if (xfer) begin
          buf_full <= 1'b1;
          buf_dat  <= word_data;
        end
        if (chain_clk_en) begin
          smp_cnt <= smp_cnt + CNT_W'(1);
          if (smp_last) begin
            rb_data <= acc | (WORD_W'(ccff_tail) << smp_idx);
            acc     <= '0;
            smp_idx <= '0;
          end else begin
            acc[smp_idx] <= ccff_tail;
            smp_idx      <= smp_idx + IDX_W'(1);
          end
        end
      end
      if (smp_done)                 rb_valid <= 1'b1;
      else if (rb_valid && rb_ready) rb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Drives two loader instances (4-bit and 70-bit chains) against a bench-side chain and stream model.
module tb_config_chain_loader;

  logic        prog_clk, prog_reset;
  logic        start_a, word_valid_a, word_ready_a, ccff_head_a, ccff_tail_a;
  logic        chain_clk_en_a, rb_valid_a, rb_ready_a, busy_a, done_a;
  logic [3:0]  word_data_a, rb_data_a;
  logic        start_b, word_valid_b, word_ready_b, ccff_head_b, ccff_tail_b;
  logic        chain_clk_en_b, rb_valid_b, rb_ready_b, busy_b, done_b;
  logic [31:0] word_data_b, rb_data_b;

  logic [3:0]  chain_a, pre_a_val;
  logic [69:0] chain_b, pre_b_val;
  logic        pre_req;

  int n_vec, n_err;

  config_chain_loader #(.CHAIN_LEN(4), .WORD_W(4), .CNT_W(8)) dut_a (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
    .word_data(word_data_a), .word_valid(word_valid_a), .word_ready(word_ready_a),
    .ccff_head(ccff_head_a), .ccff_tail(ccff_tail_a), .chain_clk_en(chain_clk_en_a),
    .rb_data(rb_data_a), .rb_valid(rb_valid_a), .rb_ready(rb_ready_a),
    .busy(busy_a), .done(done_a)
  );

  config_chain_loader #(.CHAIN_LEN(70), .WORD_W(32), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
    .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
    .ccff_head(ccff_head_b), .ccff_tail(ccff_tail_b), .chain_clk_en(chain_clk_en_b),
    .rb_data(rb_data_b), .rb_valid(rb_valid_b), .rb_ready(rb_ready_b),
    .busy(busy_b), .done(done_b)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Physical chains: head enters at the top, tail leaves from bit 0.
  always @(posedge prog_clk) begin
    if (pre_req) begin
      chain_a <= pre_a_val;
      chain_b <= pre_b_val;
    end else begin
      if (chain_clk_en_a) chain_a <= {ccff_head_a, chain_a[3:1]};
      if (chain_clk_en_b) chain_b <= {ccff_head_b, chain_b[69:1]};
    end
  end
  assign ccff_tail_a = chain_a[0];
  assign ccff_tail_b = chain_b[0];

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic b_load(input int vmode, input int hold, input int restart_at,
                        input int rst_at, output int dur, output int span);
    logic [31:0] w [3];
    logic [31:0] exp_rb [$];
    logic [69:0] stream, pre;
    int widx, en_cnt, dn, done_n, first_en, last_en, hold_left, resume_n, rb_cnt;
    bit held, in_hold, rnd, ready_chk;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    stream = {w[2][5:0], w[1], w[0]};
    pre = chain_b;
    exp_rb.push_back(pre[31:0]);
    exp_rb.push_back(pre[63:32]);
    exp_rb.push_back({26'd0, pre[69:64]});
    widx = 0; en_cnt = 0; dn = 0; done_n = 0; first_en = -1; last_en = -1;
    hold_left = 0; resume_n = -1; rb_cnt = 0; held = 0; ready_chk = 0;
    dur = -1; span = -1;
    @(posedge prog_clk); #1;
    start_b = 1'b1; word_valid_b = 1'b0; rb_ready_b = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge prog_clk); #1;
      start_b = (n == restart_at);
      if (hold > 0 && !held && rb_valid_b) begin
        held = 1; hold_left = hold;
      end
      in_hold = (hold_left > 0);
      if (in_hold) hold_left--;
      rnd = (vmode != 2) || ($urandom_range(0, 3) != 0);
      rb_ready_b = !in_hold && rnd;
      case (vmode)
        1:       word_valid_b = (widx < 3) && n[0];
        2:       word_valid_b = (widx < 3) && ($urandom_range(0, 1) == 1);
        default: word_valid_b = (widx < 3);
      endcase
      if (widx < 3) word_data_b = w[widx];
      else          word_data_b = $urandom;
      #1;
      if (n == 1) check("busy_after_start", 70'(busy_b), 70'd1);
      if (widx == 3 && !ready_chk) begin
        ready_chk = 1;
        check("ready_low_after_last_word", 70'(word_ready_b), 70'd0);
      end
      if (word_valid_b && word_ready_b) widx++;
      if (chain_clk_en_b) begin
        check("head_bit", 70'(ccff_head_b), 70'(stream[en_cnt % 70]));
        if (first_en < 0) first_en = n;
        last_en = n;
        en_cnt++;
      end
      if (in_hold && hold_left == 0) begin
        check("stall_bit_count", 70'(en_cnt), 70'd63);
        check("en_low_in_stall", 70'(chain_clk_en_b), 70'd0);
        resume_n = n + 2;
      end
      if (n == resume_n) check("resume_after_ready", 70'(chain_clk_en_b), 70'd1);
      if (rb_valid_b && rb_ready_b) begin
        rb_cnt++;
        if (exp_rb.size() > 0) check("rb_word", 70'(rb_data_b), 70'(exp_rb.pop_front()));
      end
      if (done_b) begin
        dn++; done_n = n;
        check("busy_in_done", 70'(busy_b), 70'd1);
      end
      if (rst_at > 0 && en_cnt == rst_at) begin
        prog_reset = 1'b1;
        #1;
        check("abort_outputs", 70'({word_ready_b, ccff_head_b, chain_clk_en_b, rb_valid_b,
                                     busy_b, done_b, rb_data_b}), 70'd0);
        @(posedge prog_clk); #1;
        prog_reset = 1'b0; start_b = 1'b0; word_valid_b = 1'b0; rb_ready_b = 1'b1;
        return;
      end
      if (done_n > 0 && n == done_n + 3) break;
    end
    check("busy_after_done", 70'(busy_b), 70'd0);
    check("enable_count", 70'(en_cnt), 70'd70);
    check("done_pulses", 70'(dn), 70'd1);
    check("rb_word_count", 70'(rb_cnt), 70'd3);
    check("chain_content", chain_b, stream);
    check("words_accepted", 70'(widx), 70'd3);
    dur = done_n;
    span = last_en - first_en + 1;
    word_valid_b = 1'b0; rb_ready_b = 1'b1;
  endtask

  int en_a, rb_cnt_a, dn_a, done_n_a, acc_a, dur, span;
  logic [3:0] head_seq_a, rb_a;

  initial begin
    n_vec = 0; n_err = 0;
    prog_reset = 1'b1; pre_req = 1'b0; pre_a_val = '0; pre_b_val = '0;
    start_a = 1'b0; word_valid_a = 1'b0; word_data_a = '0; rb_ready_a = 1'b1;
    start_b = 1'b0; word_valid_b = 1'b0; word_data_b = '0; rb_ready_b = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    check("reset_outputs_a", 70'({word_ready_a, ccff_head_a, chain_clk_en_a, rb_valid_a,
                                  busy_a, done_a, rb_data_a}), 70'd0);
    check("reset_outputs_b", 70'({word_ready_b, ccff_head_b, chain_clk_en_b, rb_valid_b,
                                  busy_b, done_b, rb_data_b}), 70'd0);
    prog_reset = 1'b0;
    pre_a_val = 4'b0110;
    pre_b_val = {6'($urandom), 32'($urandom), 32'($urandom)};
    pre_req = 1'b1;
    @(posedge prog_clk); #1;
    pre_req = 1'b0;

    // Small chain: one word, preloaded contents come back as the readback word.
    en_a = 0; rb_cnt_a = 0; dn_a = 0; done_n_a = 0; acc_a = 0;
    head_seq_a = '0; rb_a = '0;
    start_a = 1'b1; word_data_a = 4'hA;
    for (int n = 1; n <= 40; n++) begin
      @(posedge prog_clk); #1;
      start_a = 1'b0;
      word_valid_a = (acc_a == 0);
      #1;
      if (word_valid_a && word_ready_a) acc_a++;
      if (chain_clk_en_a) begin
        if (en_a < 4) head_seq_a[en_a] = ccff_head_a;
        en_a++;
      end
      if (rb_valid_a && rb_ready_a) begin
        rb_a = rb_data_a; rb_cnt_a++;
      end
      if (done_a) begin
        dn_a++; done_n_a = n;
      end
      if (done_n_a > 0 && n == done_n_a + 3) break;
    end
    word_valid_a = 1'b0;
    check("a_enable_count", 70'(en_a), 70'd4);
    check("a_head_sequence", 70'(head_seq_a), 70'hA);
    check("a_chain_content", 70'(chain_a), 70'hA);
    check("a_readback", 70'(rb_a), 70'h6);
    check("a_rb_count", 70'(rb_cnt_a), 70'd1);
    check("a_done_pulses", 70'(dn_a), 70'd1);
    check("a_load_cycles", 70'(done_n_a), 70'd7);

    b_load(1, 0, 0, 0, dur, span);
    b_load(0, 40, 0, 0, dur, span);
    b_load(0, 0, 30, 0, dur, span);
    check("b2b_load_cycles", 70'(dur), 70'd73);
    check("b2b_enable_span", 70'(span), 70'd70);
    b_load(2, 0, 0, 17, dur, span);
    b_load(2, 0, 0, 0, dur, span);
    b_load(2, 0, 0, 0, dur, span);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
